load_store_unit: RTL and testbench

Memory-stage load/store unit that acts as the initiator toward the data cache. It accepts one load or store per handshake from the pipeline MEM stage and drives the cache's memRead/memWrite/memToReg/address/writeData lines. It captures the cache's registered readData and returns sign- or zero-extended byte, half or word results. Sub-word stores are done as a read-modify-write of the containing word.

---
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator toward the data cache with sign/zero-extended loads.
// Define LSU_SUBWORD_EN to build byte/half loads and read-modify-write sub-word stores.
module load_store_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic        respErr,
  output logic [31:0] respData,
  output logic        memRead,
  output logic        memWrite,
  output logic        memToReg,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] address_q, address_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;
  logic        bad;
`ifdef LSU_SUBWORD_EN
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] data_q, data_d;
  logic [31:0] shifted, mask, merged, loaded;
  assign bad = reqSize == 2'd3 || (reqSize == 2'd1 && reqAddress[0])
            || (reqSize == 2'd2 && reqAddress[1:0] != 2'b00);
  assign shifted = readData >> {lane_q, 3'b000};
  assign mask    = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {lane_q, 3'b000};
  assign merged  = (readData & ~mask) | ((data_q << {lane_q, 3'b000}) & mask);
  assign loaded  = size_q == 2'd0 ? {{24{signed_q & shifted[7]}}, shifted[7:0]}
                 : size_q == 2'd1 ? {{16{signed_q & shifted[15]}}, shifted[15:0]}
                 : readData;
`else
  logic unused_ok;
  assign unused_ok = reqSigned;
  assign bad = reqSize != 2'd2 || reqAddress[1:0] != 2'b00;
`endif
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    err_d     = err_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
`ifdef LSU_SUBWORD_EN
    size_d    = size_q;
    signed_d  = signed_q;
    lane_d    = lane_q;
    data_d    = data_q;
`endif
    case (state_q)
      IDLE: if (reqValid) begin
        write_d   = reqWrite;
        err_d     = bad;
        address_d = {reqAddress[31:2], 2'b00};
        wdata_d   = reqData;
        resp_d    = '0;
`ifdef LSU_SUBWORD_EN
        size_d    = reqSize;
        signed_d  = reqSigned;
        lane_d    = reqAddress[1:0];
        data_d    = reqData;
`endif
        state_d   = bad ? DONE : (reqWrite && reqSize == 2'd2) ? WR : RD;
      end
      RD:  state_d = CAP;
      CAP: begin
`ifdef LSU_SUBWORD_EN
        state_d = write_q ? WR : DONE;
        wdata_d = write_q ? merged : wdata_q;
        resp_d  = write_q ? 32'd0 : loaded;
`else
        state_d = DONE;
        resp_d  = readData;
`endif
      end
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      resp_q    <= '0;
`ifdef LSU_SUBWORD_EN
      size_q    <= '0;
      signed_q  <= 1'b0;
      lane_q    <= '0;
      data_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      err_q     <= err_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      resp_q    <= resp_d;
`ifdef LSU_SUBWORD_EN
      size_q    <= size_d;
      signed_q  <= signed_d;
      lane_q    <= lane_d;
      data_q    <= data_d;
`endif
    end
  end
  assign reqReady  = state_q == IDLE;
  assign memRead   = state_q == RD;
  assign memWrite  = state_q == WR;
  assign memToReg  = memRead && !write_q;
  assign respValid = state_q == DONE;
  assign respErr   = respValid && err_q;
  assign respData  = resp_q;
  assign address   = address_q;
  assign writeData = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a response/write scoreboard and a cache memory model.
module tb_load_store_unit;
`ifdef LSU_SUBWORD_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        reqValid = 1'b0, reqWrite = 1'b0, reqSigned = 1'b0;
  logic [1:0]  reqSize = 2'd0;
  logic [31:0] reqAddress = '0, reqData = '0, readData = '0;
  logic        reqReady, respValid, respErr, memRead, memWrite, memToReg;
  logic [31:0] respData, address, writeData;

  load_store_unit dut (
    .clock(clock), .reset_n(reset_n), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqSize(reqSize), .reqSigned(reqSigned),
    .reqAddress(reqAddress), .reqData(reqData), .respValid(respValid),
    .respErr(respErr), .respData(respData), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .address(address), .writeData(writeData), .readData(readData)
  );

  always #5 clock = ~clock;

  typedef struct { bit err; logic [31:0] data; int lat; int acc; } resp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  int total = 0, bad = 0, cyc = 0, exp_rd = 0, act_rd = 0;
  bit cur_load = 1'b0;
  logic [31:0] mem [int unsigned];

  always @(posedge clock) cyc++;

  // single-cycle-latency cache model
  always @(posedge clock) begin
    if (memWrite) mem[address[31:2]] = writeData;
    if (memRead) readData <= mem.exists(address[31:2]) ? mem[address[31:2]] : 32'h0;
  end

  always @(negedge clock) begin
    resp_t r;
    wr_t   w;
    if (reset_n) begin
      if (respValid) begin
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected: err=%0b data=%h with nothing outstanding", respErr, respData);
        end else begin
          r = rq.pop_front();
          if (respErr !== r.err || respData !== r.data || cyc - r.acc != r.lat) begin
            bad++;
            $display("FAIL resp: got err=%0b data=%h lat=%0d, want err=%0b data=%h lat=%0d",
                     respErr, respData, cyc - r.acc, r.err, r.data, r.lat);
          end
        end
      end
      if (memWrite) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected: addr=%h data=%h", address, writeData);
        end else begin
          w = wq.pop_front();
          if (address !== w.a || writeData !== w.d) begin
            bad++;
            $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h", address, writeData, w.a, w.d);
          end
        end
      end
      if (memRead) act_rd++;
      if (memRead || memToReg) begin
        total++;
        if (memToReg !== (memRead && cur_load)) begin
          bad++;
          $display("FAIL memToReg: got %0b want %0b", memToReg, memRead && cur_load);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] d, input bit e, input logic [31:0] ed, input int lat,
                       input bit ew, input logic [31:0] wd, input bit hold);
    int n;
    resp_t r;
    wr_t   x;
    @(negedge clock);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddress = a; reqData = d;
    n = 0;
    while (!reqReady && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!reqReady) begin
      total++; bad++;
      $display("FAIL accept_timeout: addr=%h never accepted", a);
      reqValid = 1'b0;
    end else begin
      cur_load = !w;
      r.err = e; r.data = ed; r.lat = lat; r.acc = cyc + 1;
      rq.push_back(r);
      if (ew) begin
        x.a = {a[31:2], 2'b00}; x.d = wd;
        wq.push_back(x);
      end
      if (!e && (!w || sz != 2'd2)) exp_rd++;
      @(posedge clock);
      #1 if (!hold) reqValid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0 || !reqReady) && n < 100) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (rq.size() != 0 || wq.size() != 0 || !reqReady) begin
      bad++;
      $display("FAIL drain_timeout: resp pending=%0d write pending=%0d", rq.size(), wq.size());
    end
  endtask

  task automatic outputs_idle(input string tag);
    chk({tag, "_reqReady"}, {31'd0, reqReady}, 32'd1);
    chk({tag, "_respValid"}, {31'd0, respValid}, 32'd0);
    chk({tag, "_respErr"}, {31'd0, respErr}, 32'd0);
    chk({tag, "_respData"}, respData, 32'd0);
    chk({tag, "_mem_ctl"}, {29'd0, memRead, memWrite, memToReg}, 32'd0);
    chk({tag, "_address"}, address, 32'd0);
    chk({tag, "_writeData"}, writeData, 32'd0);
  endtask

  initial begin
    mem[32'h200 >> 2] = 32'h80FF7F01;
    mem[32'h300 >> 2] = 32'h11223344;
    repeat (3) @(negedge clock);
    outputs_idle("reset");
    reset_n = 1'b1;
    @(posedge clock);
    // word store then word load
    issue(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1, 1, 32'hDEADBEEF, 0);
    issue(0, 2'd2, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 2, 0, 0, 0);
    // sub-word loads from 0x80FF7F01
    issue(0, 2'd0, 1, 32'h202, 0, !SW, SW ? 32'hFFFFFFFF : 32'h0, SW ? 2 : 0, 0, 0, 0);
    issue(0, 2'd0, 0, 32'h203, 0, !SW, SW ? 32'h00000080 : 32'h0, SW ? 2 : 0, 0, 0, 0);
    issue(0, 2'd1, 1, 32'h202, 0, !SW, SW ? 32'hFFFF80FF : 32'h0, SW ? 2 : 0, 0, 0, 0);
    issue(0, 2'd1, 0, 32'h200, 0, !SW, SW ? 32'h00007F01 : 32'h0, SW ? 2 : 0, 0, 0, 0);
    issue(0, 2'd0, 1, 32'h200, 0, !SW, SW ? 32'h00000001 : 32'h0, SW ? 2 : 0, 0, 0, 0);
    // read-modify-write stores into 0x11223344
    issue(1, 2'd0, 0, 32'h301, 32'h123456AA, !SW, 0, SW ? 3 : 0, SW, 32'h1122AA44, 0);
    issue(0, 2'd2, 0, 32'h300, 0, 0, SW ? 32'h1122AA44 : 32'h11223344, 2, 0, 0, 0);
    issue(1, 2'd1, 0, 32'h302, 32'h5555BEEF, !SW, 0, SW ? 3 : 0, SW, 32'hBEEFAA44, 0);
    issue(0, 2'd2, 1, 32'h300, 0, 0, SW ? 32'hBEEFAA44 : 32'h11223344, 2, 0, 0, 0);
    // misaligned and reserved requests
    issue(0, 2'd2, 0, 32'h102, 0, 1, 0, 0, 0, 0, 0);
    issue(1, 2'd2, 0, 32'h103, 32'h12345678, 1, 0, 0, 0, 0, 0);
    issue(1, 2'd1, 0, 32'h101, 32'h1234, 1, 0, 0, 0, 0, 0);
    issue(0, 2'd1, 1, 32'h101, 0, 1, 0, 0, 0, 0, 0);
    issue(0, 2'd3, 0, 32'h100, 0, 1, 0, 0, 0, 0, 0);
    issue(1, 2'd3, 0, 32'h100, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0);
    issue(0, 2'd0, 0, 32'h100, 0, !SW, SW ? 32'h000000EF : 32'h0, SW ? 2 : 0, 0, 0, 0);
    // back-to-back word stores with reqValid held high
    issue(1, 2'd2, 0, 32'h400, 32'h11111111, 0, 0, 1, 1, 32'h11111111, 1);
    issue(1, 2'd2, 0, 32'h404, 32'h22222222, 0, 0, 1, 1, 32'h22222222, 0);
    issue(0, 2'd2, 0, 32'h400, 0, 0, 32'h11111111, 2, 0, 0, 0);
    issue(0, 2'd2, 0, 32'h404, 0, 0, 32'h22222222, 2, 0, 0, 0);
    drain();
    // reset while in CAP: sub-word store if built, otherwise a word load
    @(negedge clock);
    reqValid = 1'b1; reqWrite = SW; reqSize = SW ? 2'd0 : 2'd2; reqSigned = 1'b0;
    reqAddress = 32'h300; reqData = 32'h000000CC;
    cur_load = !SW;
    exp_rd++;
    @(posedge clock);
    #1 reqValid = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 outputs_idle("abort");
    repeat (3) @(negedge clock);
    chk("abort_no_write", {31'd0, memWrite}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1 outputs_idle("release");
    issue(0, 2'd2, 0, 32'h300, 0, 0, SW ? 32'hBEEFAA44 : 32'h11223344, 2, 0, 0, 0);
    issue(0, 2'd2, 0, 32'h404, 0, 0, 32'h22222222, 2, 0, 0, 0);
    drain();
    repeat (3) @(negedge clock);
    chk("mem_read_count", act_rd, exp_rd);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
